fpu_issue_ctrl: RTL and testbench
=================================

# fpu_issue_ctrl

Issue sequencer for the FPU ALU datapath. It accepts one decoded FP instruction at a time over a valid/ready handshake and drives the ALU's operand buses and one-hot operation strobes. It waits the op's latency, then samples the ALU result or compare flag. Results go out as a register-file writeback pulse; branch ops produce a branch-resolution pulse. It sits between the FP decode stage and the FPU ALU.

## Interface
Parameters:
- MUL_LAT, 4: cycles the MUL strobe is held before the result is sampled (≥1)
- DIV_LAT, 16: cycles the DIV strobe is held before the result is sampled (≥1)
- RA_W, 5: register address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept an instruction
- instr_op  in  4  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 INV, 5 ABS, 6 COM, 7 BLT, 8 BEQ, 9 BGT, 10–15 illegal
- instr_rd  in  RA_W  destination register
- instr_a, instr_b  in  32  operand values
- alu_op1, alu_op2  out  32  operands to the ALU
- alu_add, alu_sub, alu_mul, alu_div, alu_inv, alu_abs, alu_com, alu_blt, alu_beq, alu_bgt  out  1 each  operation strobes
- alu_result  in  32  ALU result
- alu_com_result  in  1  ALU compare flag
- wb_valid  out  1  one-cycle writeback pulse
- wb_addr  out  RA_W  writeback register
- wb_data  out  32  writeback value
- br_valid  out  1  one-cycle branch-resolved pulse
- br_taken  out  1  branch outcome, valid with br_valid
- illegal  out  1  one-cycle pulse on an illegal opcode
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, WAIT, EVAL, DONE.
- IDLE:
  - instr_ready=1. Handshake occurs when instr_valid && instr_ready at a rising edge.
  - On a legal opcode: capture op, rd, a, b; go to ISSUE.
  - On an illegal opcode: capture nothing; pulse illegal the next cycle; stay IDLE.
- Operands: alu_op1/alu_op2 carry the captured a/b from ISSUE through DONE and hold their last value in IDLE.
- Strobes: registered; at most one op strobe is high, except in EVAL, where alu_com and one branch strobe are high together.
- ISSUE, by op:
  - ADD/SUB/INV/ABS/COM: assert the matching strobe for exactly 1 cycle. Sample alu_result at the end of ISSUE; go to DONE.
  - MUL/DIV: assert the strobe and load the counter with LAT−1. Go to WAIT, or to DONE if LAT=1.
  - BLT/BEQ/BGT: assert alu_com only; go to EVAL.
- WAIT: hold the strobe and decrement the counter. At count 0, sample alu_result at the end of that cycle and go to DONE. The total strobe-high time is exactly LAT cycles.
- EVAL: assert alu_com plus the branch strobe for 1 cycle. Sample alu_com_result into br_taken at the end of EVAL; go to DONE.
- DONE: all strobes low.
  - Non-branch op: wb_valid=1, wb_addr=rd, wb_data=sampled result.
  - Branch op: br_valid=1, br_taken=sampled flag, and no writeback.
  - Next state is IDLE.
- Writeback rules: COM writes back its result. Branch ops never write back. wb_addr/wb_data hold their values after the pulse.

## Timing
- Handshake at edge T0. The numbers below are the cycle at which wb_valid/br_valid is high. instr_ready returns to 1 in the cycle after that.
  - ADD/SUB/INV/ABS/COM: strobe in cycle T0+1; wb_valid in cycle T0+2.
  - MUL/DIV: strobe in cycles T0+1 .. T0+LAT; wb_valid in cycle T0+LAT+1.
  - Branch: alu_com in cycles T0+1 and T0+2, branch strobe in cycle T0+2; br_valid in cycle T0+3.
- Throughput: one instruction per (latency+1) cycles. No overlap; instr_ready=0 whenever busy=1.
- Reset values:
  - State IDLE, so instr_ready=1 during and after reset.
  - All strobes, wb_valid, br_valid, br_taken, illegal and busy are 0.
  - alu_op1, alu_op2, wb_addr and wb_data are 0. The counter is 0.
- Reset mid-operation: all strobes drop asynchronously. The in-flight instruction is discarded, with no wb_valid, br_valid or illegal pulse.
- instr_valid while busy is ignored; the upstream holds it until the handshake.

## Test plan
- ADD: a=0x00000005, b=0x00000003, rd=7, accept at T0. Required: alu_add high only in cycle T0+1; wb_valid in cycle T0+2 with wb_addr=7, wb_data=0x00000008; instr_ready high again in cycle T0+3.
- MUL, MUL_LAT=4, bench ALU returns 0x00000014 for a=4, b=5. Required: alu_mul high exactly in cycles T0+1..T0+4; wb_valid in cycle T0+5 with wb_data=0x00000014; no other strobe high.
- BEQ with a=b=0x3F800000, bench ALU com_result=1. Required: alu_com in cycles T0+1 and T0+2; alu_beq only in cycle T0+2; br_valid=1, br_taken=1 in cycle T0+3; wb_valid never high.
- Same sequence with BGT and bench com_result=0. Required: br_valid=1, br_taken=0 in cycle T0+3.
- Illegal opcode 12 offered. Required: illegal=1 for one cycle after the handshake; no strobe, wb_valid or br_valid; instr_ready stays 1.
- DIV (DIV_LAT=16): assert rst in cycle T0+6. Required: alu_div low immediately; no wb_valid; after deassert, instr_ready=1. A following ADD completes normally with its required latency.

Source files
------------

// File: rtl/fpu_issue_ctrl.sv
// Issue sequencer between FP decode and the FPU ALU: one instruction in flight,
// drives operands and one-hot strobes, waits op latency, emits writeback or branch pulse.
module fpu_issue_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 16,
    parameter int unsigned RA_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [3:0]      instr_op,
    input  logic [RA_W-1:0] instr_rd,
    input  logic [31:0]     instr_a,
    input  logic [31:0]     instr_b,
    output logic [31:0]     alu_op1,
    output logic [31:0]     alu_op2,
    output logic            alu_add,
    output logic            alu_sub,
    output logic            alu_mul,
    output logic            alu_div,
    output logic            alu_inv,
    output logic            alu_abs,
    output logic            alu_com,
    output logic            alu_blt,
    output logic            alu_beq,
    output logic            alu_bgt,
    input  logic [31:0]     alu_result,
    input  logic            alu_com_result,
    output logic            wb_valid,
    output logic [RA_W-1:0] wb_addr,
    output logic [31:0]     wb_data,
    output logic            br_valid,
    output logic            br_taken,
    output logic            illegal,
    output logic            busy
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;
    localparam int unsigned N_STRB  = 10;

    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_BLT = 4'd7;
    localparam logic [3:0] OP_BGT = 4'd9;

    localparam logic [N_STRB-1:0] COM_BIT = N_STRB'(1) << 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_EVAL,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_op;
    logic [RA_W-1:0]   r_rd;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt;
    logic [N_STRB-1:0] r_strb;
    logic [N_STRB-1:0] w_strb;
    logic [N_STRB-1:0] w_onehot;
    logic [3:0]        w_op;
    logic              w_hs;
    logic              w_legal;
    logic              w_is_br;
    logic              w_sample;
    logic              w_br_sample;

    // Handshake is only possible in IDLE; instr_ready mirrors that state.
    assign w_hs     = (r_state == S_IDLE) && instr_valid;
    assign w_legal  = (instr_op <= OP_BGT);
    assign w_op     = w_hs ? instr_op : r_op;
    assign w_is_br  = (w_op >= OP_BLT) && (w_op <= OP_BGT);
    assign w_onehot = N_STRB'(1) << w_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, counter and sample points.
    always_comb begin
        w_next      = r_state;
        w_cnt       = r_cnt;
        w_sample    = 1'b0;
        w_br_sample = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hs && w_legal) begin
                    w_next = S_ISSUE;
                    if (instr_op == OP_MUL) begin
                        w_cnt = CNT_W'(MUL_LAT - 1);
                    end else if (instr_op == OP_DIV) begin
                        w_cnt = CNT_W'(DIV_LAT - 1);
                    end else begin
                        w_cnt = '0;
                    end
                end
            end
            S_ISSUE: begin
                if (r_op == OP_MUL || r_op == OP_DIV) begin
                    if (r_cnt == '0) begin
                        w_next   = S_DONE;
                        w_sample = 1'b1;
                    end else begin
                        w_next = S_WAIT;
                        w_cnt  = r_cnt - CNT_W'(1);
                    end
                end else if (w_is_br) begin
                    w_next = S_EVAL;
                end else begin
                    w_next   = S_DONE;
                    w_sample = 1'b1;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_next   = S_DONE;
                    w_sample = 1'b1;
                end else begin
                    w_cnt = r_cnt - CNT_W'(1);
                end
            end
            S_EVAL: begin
                w_next      = S_DONE;
                w_br_sample = 1'b1;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Strobes are registered from the upcoming state so they align with it.
    always_comb begin
        w_strb = '0;
        case (w_next)
            S_ISSUE: w_strb = w_is_br ? COM_BIT : w_onehot;
            S_WAIT:  w_strb = w_onehot;
            S_EVAL:  w_strb = w_onehot | COM_BIT;
            default: w_strb = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op        <= '0;
            r_rd        <= '0;
            r_cnt       <= '0;
            r_strb      <= '0;
            alu_op1     <= '0;
            alu_op2     <= '0;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            wb_valid    <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            br_valid    <= 1'b0;
            br_taken    <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            r_cnt       <= w_cnt;
            r_strb      <= w_strb;
            instr_ready <= (w_next == S_IDLE);
            busy        <= (w_next != S_IDLE);
            wb_valid    <= w_sample;
            br_valid    <= w_br_sample;
            illegal     <= w_hs && !w_legal;
            if (w_hs && w_legal) begin
                r_op    <= instr_op;
                r_rd    <= instr_rd;
                alu_op1 <= instr_a;
                alu_op2 <= instr_b;
            end
            if (w_sample) begin
                wb_addr <= r_rd;
                wb_data <= alu_result;
            end
            if (w_br_sample) begin
                br_taken <= alu_com_result;
            end
        end
    end

    assign alu_add = r_strb[0];
    assign alu_sub = r_strb[1];
    assign alu_mul = r_strb[2];
    assign alu_div = r_strb[3];
    assign alu_inv = r_strb[4];
    assign alu_abs = r_strb[5];
    assign alu_com = r_strb[6];
    assign alu_blt = r_strb[7];
    assign alu_beq = r_strb[8];
    assign alu_bgt = r_strb[9];

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl: directed instructions push expected strobes,
// busy windows and output pulses; a negedge monitor compares every cycle.
module tb_fpu_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_op;
    logic [4:0]  instr_rd;
    logic [31:0] instr_a;
    logic [31:0] instr_b;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic        alu_add, alu_sub, alu_mul, alu_div, alu_inv;
    logic        alu_abs, alu_com, alu_blt, alu_beq, alu_bgt;
    logic [31:0] alu_result;
    logic        alu_com_result;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        br_valid;
    logic        br_taken;
    logic        illegal;
    logic        busy;

    fpu_issue_ctrl #(.MUL_LAT(4), .DIV_LAT(16), .RA_W(5)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_a(instr_a), .instr_b(instr_b),
        .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_add(alu_add), .alu_sub(alu_sub), .alu_mul(alu_mul), .alu_div(alu_div),
        .alu_inv(alu_inv), .alu_abs(alu_abs), .alu_com(alu_com), .alu_blt(alu_blt),
        .alu_beq(alu_beq), .alu_bgt(alu_bgt),
        .alu_result(alu_result), .alu_com_result(alu_com_result),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .br_valid(br_valid), .br_taken(br_taken), .illegal(illegal), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic tb_flag;
    assign alu_com_result = tb_flag;

    // Behavioural ALU stand-in driven by whichever strobe is active.
    always_comb begin
        alu_result = 32'd0;
        if (alu_add)      alu_result = alu_op1 + alu_op2;
        else if (alu_sub) alu_result = alu_op1 - alu_op2;
        else if (alu_mul) alu_result = alu_op1 * alu_op2;
        else if (alu_div) alu_result = (alu_op2 != 32'd0) ? alu_op1 / alu_op2 : 32'd0;
        else if (alu_inv) alu_result = ~alu_op1;
        else if (alu_abs) alu_result = {1'b0, alu_op1[30:0]};
        else if (alu_com) alu_result = {31'd0, alu_op1 == alu_op2};
    end

    typedef struct {
        int          kind;   // 0 writeback, 1 branch, 2 illegal
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        taken;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    ev_t         q[$];
    ev_t         mon_e;
    logic [9:0]  exp_strb [int];
    bit          exp_busy [int];
    int          cyc;
    int          n_checks;
    int          n_fail;
    logic [9:0]  act_strb;
    logic [9:0]  mon_es;
    bit          mon_eb;
    logic [2:0]  mon_pulse;
    logic [2:0]  mon_exp_pulse;

    assign act_strb = {alu_bgt, alu_beq, alu_blt, alu_com, alu_abs,
                       alu_inv, alu_div, alu_mul, alu_sub, alu_add};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [4:0] rd, input logic [31:0] a,
                         input logic [31:0] b, input logic flag, output int t1);
        int n;
        n = 0;
        @(negedge clk);
        while (!instr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) check("ready_timeout", 64'(instr_ready), 64'd1);
        tb_flag     = flag;
        instr_valid = 1'b1;
        instr_op    = op;
        instr_rd    = rd;
        instr_a     = a;
        instr_b     = b;
        @(posedge clk);
        #1;
        t1          = cyc;
        instr_valid = 1'b0;
        instr_a     = 32'hDEAD_BEEF;
        instr_b     = 32'hDEAD_BEEF;
    endtask

    task automatic exp_alu(input int t, input int bitn, input int lat, input logic [4:0] rd,
                           input logic [31:0] d, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        for (int i = 0; i < lat; i++) exp_strb[t + i] = 10'(1) << bitn;
        for (int i = 0; i <= lat; i++) exp_busy[t + i] = 1'b1;
        e.kind = 0; e.cyc = t + lat; e.addr = rd; e.data = d; e.taken = 1'b0;
        e.a = a; e.b = b;
        q.push_back(e);
    endtask

    task automatic exp_br(input int t, input int bitn, input logic taken,
                          input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        exp_strb[t]     = 10'h040;
        exp_strb[t + 1] = 10'h040 | (10'(1) << bitn);
        for (int i = 0; i <= 2; i++) exp_busy[t + i] = 1'b1;
        e.kind = 1; e.cyc = t + 2; e.addr = '0; e.data = '0; e.taken = taken;
        e.a = a; e.b = b;
        q.push_back(e);
    endtask

    // Monitor: per-cycle strobe/busy/ready checks and scoreboard pops on output pulses.
    always @(negedge clk) begin
        mon_es = exp_strb.exists(cyc) ? exp_strb[cyc] : 10'd0;
        mon_eb = exp_busy.exists(cyc);
        check("strobes", 64'(act_strb), 64'(mon_es));
        check("busy", 64'(busy), 64'(mon_eb));
        check("instr_ready", 64'(instr_ready), 64'(!mon_eb));
        mon_pulse = {wb_valid, br_valid, illegal};
        if (mon_pulse != 3'b000) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", 64'(mon_pulse), 64'd0);
            end else begin
                mon_e = q.pop_front();
                mon_exp_pulse = (mon_e.kind == 0) ? 3'b100 : (mon_e.kind == 1) ? 3'b010 : 3'b001;
                check("pulse_kind", 64'(mon_pulse), 64'(mon_exp_pulse));
                check("pulse_cycle", 64'(cyc), 64'(mon_e.cyc));
                if (mon_e.kind == 0) begin
                    check("wb_addr", 64'(wb_addr), 64'(mon_e.addr));
                    check("wb_data", 64'(wb_data), 64'(mon_e.data));
                end
                if (mon_e.kind == 1) check("br_taken", 64'(br_taken), 64'(mon_e.taken));
                if (mon_e.kind != 2) begin
                    check("alu_op1", 64'(alu_op1), 64'(mon_e.a));
                    check("alu_op2", 64'(alu_op2), 64'(mon_e.b));
                end
            end
        end else if (q.size() > 0 && q[0].cyc < cyc) begin
            check("missing_pulse", 64'(cyc), 64'(q[0].cyc));
            void'(q.pop_front());
        end
    end

    initial begin
        int t;
        cyc = 0; n_checks = 0; n_fail = 0;
        rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rd = '0;
        instr_a = '0; instr_b = '0; tb_flag = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_alu_op1", 64'(alu_op1), 64'd0);
        check("rst_wb_data", 64'(wb_data), 64'd0);
        check("rst_wb_addr", 64'(wb_addr), 64'd0);
        check("rst_br_taken", 64'(br_taken), 64'd0);
        rst = 1'b0;

        issue(4'd0, 5'd7, 32'h5, 32'h3, 1'b0, t);
        exp_alu(t, 0, 1, 5'd7, 32'h8, 32'h5, 32'h3);
        issue(4'd1, 5'd1, 32'd10, 32'd3, 1'b0, t);
        exp_alu(t, 1, 1, 5'd1, 32'd7, 32'd10, 32'd3);
        issue(4'd2, 5'd2, 32'd4, 32'd5, 1'b0, t);
        exp_alu(t, 2, 4, 5'd2, 32'h14, 32'd4, 32'd5);
        issue(4'd5, 5'd3, 32'hBF80_0000, 32'h0, 1'b0, t);
        exp_alu(t, 5, 1, 5'd3, 32'h3F80_0000, 32'hBF80_0000, 32'h0);
        issue(4'd6, 5'd4, 32'h3F80_0000, 32'h3F80_0000, 1'b0, t);
        exp_alu(t, 6, 1, 5'd4, 32'h1, 32'h3F80_0000, 32'h3F80_0000);
        issue(4'd8, 5'd5, 32'h3F80_0000, 32'h3F80_0000, 1'b1, t);
        exp_br(t, 8, 1'b1, 32'h3F80_0000, 32'h3F80_0000);
        issue(4'd9, 5'd6, 32'h3F80_0000, 32'h3F80_0000, 1'b0, t);
        exp_br(t, 9, 1'b0, 32'h3F80_0000, 32'h3F80_0000);

        issue(4'd12, 5'd8, 32'h1, 32'h2, 1'b0, t);
        mon_e.kind = 2; mon_e.cyc = t; mon_e.addr = '0; mon_e.data = '0;
        mon_e.taken = 1'b0; mon_e.a = '0; mon_e.b = '0;
        q.push_back(mon_e);

        // DIV interrupted by reset in its sixth strobe cycle.
        issue(4'd3, 5'd9, 32'd100, 32'd5, 1'b0, t);
        for (int i = 0; i < 5; i++) begin
            exp_strb[t + i] = 10'h008;
            exp_busy[t + i] = 1'b1;
        end
        repeat (5) @(posedge clk);
        #2;
        check("div_before_rst", 64'(alu_div), 64'd1);
        rst = 1'b1;
        #1;
        check("div_async_drop", 64'(alu_div), 64'd0);
        check("busy_async_drop", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("ready_after_rst", 64'(instr_ready), 64'd1);

        issue(4'd0, 5'd31, 32'h100, 32'h23, 1'b0, t);
        exp_alu(t, 0, 1, 5'd31, 32'h123, 32'h100, 32'h23);

        repeat (6) @(negedge clk);
        check("queue_empty", 64'(q.size()), 64'd0);
        check("wb_data_hold", 64'(wb_data), 64'h123);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
